// File: rtl/gmii_tx_arbiter.sv
// Purpose: merges the ARP and UDP GMII transmit streams onto one GMII port using round-robin req/grant.
// Latency: granted source data appears on gmii_txd/gmii_tx_en exactly one gmii_tx_clk cycle later.
// Backpressure: none on data; sources wait on grant, and the inter-frame gap plus stall/overlength policing bound the medium time each source holds.
module gmii_tx_arbiter #(
    parameter int IFG_CYCLES       = 12,
    parameter int START_TIMEOUT    = 255,
    parameter int MAX_FRAME_CYCLES = 1530
) (
    input  logic        gmii_tx_clk,
    input  logic        sys_rst,
    input  logic        arp_req,
    output logic        arp_grant,
    input  logic        arp_tx_en,
    input  logic [7:0]  arp_txd,
    input  logic        udp_req,
    output logic        udp_grant,
    input  logic        udp_tx_en,
    input  logic [7:0]  udp_txd,
    output logic        gmii_tx_en,
    output logic [7:0]  gmii_txd,
    output logic        gmii_tx_er,
    output logic        busy,
    output logic [15:0] frame_cnt,
    output logic [7:0]  err_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        XFER,
        DRAIN,
        IFG
    } state_t;

    // One counter serves as start-wait counter (GRANT), frame length (XFER) and gap counter (IFG).
    localparam int            CW       = 16;
    localparam logic [CW-1:0] TO_LAST  = CW'(START_TIMEOUT - 1);
    localparam logic [CW-1:0] LEN_MAX  = CW'(MAX_FRAME_CYCLES);
    localparam logic [CW-1:0] IFG_LAST = CW'(IFG_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    // Source encoding for sel/last_winner: 0 = ARP, 1 = UDP.
    state_t        state_q, state_nxt;
    logic [CW-1:0] cnt_q, cnt_nxt;
    logic          sel_q, sel_nxt;
    logic          last_q, last_nxt;

    logic          arp_grant_nxt, udp_grant_nxt;
    logic          tx_en_nxt, tx_er_nxt;
    logic [7:0]    txd_nxt;
    logic [15:0]   frame_nxt;
    logic [7:0]    err_nxt;
    logic [7:0]    err_inc;
    logic [CW-1:0] len_inc;
    logic          win;
    logic          holds_grant;

    logic          src_tx_en;
    logic [7:0]    src_txd;

    // The non-granted source is never looked at: only the selected stream feeds the datapath.
    assign src_tx_en = sel_q ? udp_tx_en : arp_tx_en;
    assign src_txd   = sel_q ? udp_txd   : arp_txd;

    // State register and all registered outputs; async reset drops the GMII outputs immediately.
    always_ff @(posedge gmii_tx_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sel_q      <= 1'b0;
            last_q     <= 1'b1;
            arp_grant  <= 1'b0;
            udp_grant  <= 1'b0;
            gmii_tx_en <= 1'b0;
            gmii_txd   <= 8'h00;
            gmii_tx_er <= 1'b0;
            busy       <= 1'b0;
            frame_cnt  <= 16'h0000;
            err_cnt    <= 8'h00;
        end else begin
            state_q    <= state_nxt;
            cnt_q      <= cnt_nxt;
            sel_q      <= sel_nxt;
            last_q     <= last_nxt;
            arp_grant  <= arp_grant_nxt;
            udp_grant  <= udp_grant_nxt;
            gmii_tx_en <= tx_en_nxt;
            gmii_txd   <= txd_nxt;
            gmii_tx_er <= tx_er_nxt;
            busy       <= (state_nxt != IDLE);
            frame_cnt  <= frame_nxt;
            err_cnt    <= err_nxt;
        end
    end

    // Next-state, counter and output decode for arbitration, forwarding and policing.
    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        sel_nxt   = sel_q;
        last_nxt  = last_q;
        tx_en_nxt = 1'b0;
        txd_nxt   = 8'h00;
        tx_er_nxt = 1'b0;
        frame_nxt = frame_cnt;
        err_nxt   = err_cnt;
        win       = 1'b0;
        err_inc   = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'h01;
        // Length the current byte would give the frame; the first byte is taken straight from GRANT.
        len_inc   = (state_q == GRANT) ? CNT_ONE : cnt_q + CNT_ONE;

        case (state_q)
            IDLE: begin
                if (arp_req || udp_req) begin
                    // On a tie the source that did not win last time goes next.
                    win       = (arp_req && udp_req) ? ~last_q : udp_req;
                    sel_nxt   = win;
                    last_nxt  = win;
                    cnt_nxt   = '0;
                    state_nxt = GRANT;
                end
            end

            GRANT, XFER: begin
                if (src_tx_en) begin
                    tx_en_nxt = 1'b1;
                    txd_nxt   = src_txd;
                    cnt_nxt   = len_inc;
                    if (len_inc == LEN_MAX) begin
                        // Last allowed byte goes out flagged; the rest of the frame is swallowed.
                        tx_er_nxt = 1'b1;
                        err_nxt   = err_inc;
                        state_nxt = DRAIN;
                    end else begin
                        state_nxt = XFER;
                    end
                end else if (state_q == XFER) begin
                    frame_nxt = frame_cnt + 16'h0001;
                    cnt_nxt   = '0;
                    state_nxt = IFG;
                end else if (cnt_q == TO_LAST) begin
                    // Source never started: reclaim the medium. Dropping req does not end GRANT.
                    err_nxt   = err_inc;
                    cnt_nxt   = '0;
                    state_nxt = IFG;
                end else begin
                    cnt_nxt = cnt_q + CNT_ONE;
                end
            end

            DRAIN: begin
                if (!src_tx_en) begin
                    cnt_nxt   = '0;
                    state_nxt = IFG;
                end
            end

            IFG: begin
                // Requests seen here simply stay pending; arbitration happens back in IDLE.
                if (cnt_q == IFG_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt_q + CNT_ONE;
                end
            end

            default: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase

        // Grant is a pure function of where the FSM is heading, so it falls on the ending edge.
        holds_grant   = (state_nxt == GRANT) || (state_nxt == XFER);
        arp_grant_nxt = holds_grant && !sel_nxt;
        udp_grant_nxt = holds_grant && sel_nxt;
    end

endmodule

// File: doc/gmii_tx_arbiter.md
Name: gmii_tx_arbiter

Overview:
- Downstream of the ARP engine and the planned UDP engine. Merges their GMII transmit streams onto the single gmii_txd/gmii_tx_en pair that feeds the SGMII/GMII converter.
- Grants one source at a time using round-robin and a req/grant handshake.
- Forwards the granted stream with one cycle of register latency.
- Enforces the inter-frame gap and polices stalled or overlong frames.

Parameters:
- IFG_CYCLES, 12, idle cycles forced between frames (minimum 1).
- START_TIMEOUT, 255, cycles a granted source may hold grant without raising tx_en before the grant is revoked.
- MAX_FRAME_CYCLES, 1530, maximum tx_en-high cycles per frame (preamble and FCS included) before truncation.

Ports:
- gmii_tx_clk, in, 1, 125 MHz transmit clock.
- sys_rst, in, 1, reset.
- arp_req, in, 1, ARP source requests the medium; level, held until grant is seen.
- arp_grant, out, 1, ARP source owns the medium.
- arp_tx_en, in, 1, ARP GMII data valid.
- arp_txd, in, 8, ARP GMII data.
- udp_req, in, 1, UDP source request.
- udp_grant, out, 1, UDP source owns the medium.
- udp_tx_en, in, 1, UDP GMII data valid.
- udp_txd, in, 8, UDP GMII data.
- gmii_tx_en, out, 1, merged data valid to the SGMII converter.
- gmii_txd, out, 8, merged data.
- gmii_tx_er, out, 1, error flag; pulses on truncation.
- busy, out, 1, high in any state other than IDLE.
- frame_cnt, out, 16, frames forwarded; wraps at 0xFFFF to 0.
- err_cnt, out, 8, timeouts plus truncations; saturates at 0xFF.

Behaviour:
- Reset is asynchronous and active-high (sys_rst); clock is gmii_tx_clk. Every output resets to 0. State resets to IDLE. last_winner resets to UDP, so ARP wins the first tie.
- Reset mid-frame: gmii_tx_en and gmii_txd drop to 0 immediately. No gmii_tx_er is generated.
- All outputs are registered.
- States: IDLE, GRANT, XFER, DRAIN, IFG.
- IDLE:
  - Only one req high: that source wins.
  - Both req high: the source other than last_winner wins.
  - The winner's grant goes high on the next edge and the state moves to GRANT. last_winner is updated.
  - No req: stay in IDLE.
- GRANT:
  - The grant holds. The wait counter increments each cycle.
  - Granted source tx_en high: go to XFER. The first byte is forwarded, so gmii_tx_en/txd appear one cycle after the source's.
  - Counter reaches START_TIMEOUT with tx_en never high: drop grant, increment err_cnt, go to IFG.
- XFER:
  - gmii_tx_en <= src_tx_en and gmii_txd <= src_txd each cycle (latency exactly 1). A length counter counts tx_en-high cycles.
  - Source tx_en falls: the same edge registers gmii_tx_en=0, drops grant, increments frame_cnt, and enters IFG.
  - Length counter reaches MAX_FRAME_CYCLES with tx_en still high: the output cycle carrying byte number MAX_FRAME_CYCLES has gmii_tx_er=1 alongside gmii_tx_en=1. The next cycle has both 0. Grant drops, err_cnt increments, frame_cnt does not, and the state goes to DRAIN.
- DRAIN:
  - Outputs stay 0. The source's tx_en is ignored until it goes low, then enter IFG.
- IFG:
  - Counts IFG_CYCLES cycles with gmii_tx_en=0, then returns to IDLE.
  - Requests arriving during IFG are held pending and arbitrated in IDLE. The earliest new grant comes IFG_CYCLES+1 cycles after the last tx_en output.
- Data from the non-granted source is ignored at all times.
- tx_en pulsing high while no grant is active is ignored.
- gmii_txd is forced to 0x00 whenever gmii_tx_en=0.
- A source that drops req while in GRANT does not shorten the grant. Only tx_en activity or the timeout ends it.
- Back-to-back frames from one source: the source must re-request after its grant falls. When both sources keep req high, grants alternate.

Test Plan:
- Single ARP frame: arp_req=1, then 64 bytes on arp_tx_en. Expect arp_grant one cycle after req and gmii output identical to input delayed by 1 cycle. frame_cnt=1. No new grant within 12 cycles after the last tx_en.
- Tie: arp_req and udp_req both rise on the same edge after reset, each sending 60-byte frames. Expect grant order ARP, UDP, ARP, UDP. Output frames are separated by at least 12 idle cycles and never overlap.
- Start timeout: udp_req=1 with udp_tx_en never asserted. Expect udp_grant to drop after 255 cycles and err_cnt=1. A pending arp_req is then granted after IFG.
- Overlength: ARP holds tx_en for 2000 cycles. Expect gmii_tx_er=1 on output byte 1530 together with gmii_tx_en=1, then tx_en=0. The state stays in DRAIN until arp_tx_en falls. err_cnt increments and frame_cnt is unchanged.
- Reset mid-frame: assert sys_rst during byte 30 of a UDP frame. Expect all outputs 0 immediately. After release the state is IDLE and a tie goes to ARP.
- Intruder: udp_tx_en toggles with random data during an ARP frame. Expect gmii_txd to match the ARP data only.
